// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 serial transmitter with an 8-entry byte FIFO
// Clock/Reset : system clock, async active-high reset
// ADDR/DOUT/W : processor bus; DATA at BASE_ADDR pushes a byte, STATUS at BASE_ADDR+1
// rdata/hit   : registered read data and address-match flag for the DIN mux
// tx          : serial output, idles high
module mmio_uart_tx #(
    parameter logic [15:0] BASE_ADDR    = 16'h3000,
    parameter int          CLKS_PER_BIT = 434,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [15:0] ADDR,
    input  logic [15:0] DOUT,
    input  logic        W,
    output logic [15:0] rdata,
    output logic        hit,
    output logic        tx
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH = FIFO_DEPTH[AW:0];
    localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    state_t        state_q;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wp_q, rp_q;
    logic [AW:0]   count_q, count_d;
    logic          ovf_q;
    logic [15:0]   cnt_q;
    logic [2:0]    idx_q;
    logic [7:0]    shift_q;
    logic          sel_data, sel_stat, full, empty, push, pop, bit_end;
    logic [15:0]   status;
    logic          unused_hi;
    assign unused_hi = ^DOUT[15:8];
    assign sel_data = ADDR == BASE_ADDR;
    assign sel_stat = ADDR == BASE_ADDR + 16'd1;
    assign full     = count_q == DEPTH;
    assign empty    = count_q == '0;
    // fullness is judged on the pre-edge count, so a same-edge pop cannot rescue a push
    assign push     = W && sel_data && !full;
    assign pop      = state_q == IDLE && !empty;
    assign count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop);
    assign bit_end  = cnt_q == LAST;
    assign status   = {8'h00, 4'(count_q), ovf_q, state_q != IDLE, empty, full};
    always_ff @(posedge Clock) begin
        if (push) mem_q[wp_q] <= DOUT[7:0];
    end
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            tx      <= 1'b1;
            rdata   <= 16'h0000;
            hit     <= 1'b0;
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
        end else begin
            hit     <= sel_data || sel_stat;
            rdata   <= sel_stat ? status : 16'h0000;
            count_q <= count_d;
            if (push) wp_q <= wp_q + AW'(1);
            if (W && sel_data && full) ovf_q <= 1'b1;
            else if (W && sel_stat && DOUT[3]) ovf_q <= 1'b0;
            cnt_q <= (state_q == IDLE || bit_end) ? '0 : cnt_q + 16'd1;
            case (state_q)
                IDLE: if (pop) begin
                    shift_q <= mem_q[rp_q];
                    rp_q    <= rp_q + AW'(1);
                    idx_q   <= '0;
                    tx      <= 1'b0;
                    state_q <= START;
                end
                START: if (bit_end) begin
                    tx      <= shift_q[0];
                    state_q <= DATA;
                end
                DATA: if (bit_end) begin
                    // tx takes the next bit from the pre-shift register, or the stop bit after bit 7
                    shift_q <= shift_q >> 1;
                    idx_q   <= idx_q + 3'd1;
                    tx      <= idx_q == 3'd7 ? 1'b1 : shift_q[1];
                    if (idx_q == 3'd7) state_q <= STOP;
                end
                STOP: if (bit_end) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: directed bench for mmio_uart_tx at 4, 1000 and 2 clocks per bit
module tb_mmio_uart_tx;
    logic        Clock = 1'b0, Reset = 1'b1, W = 1'b0;
    logic [15:0] ADDR = 16'h0000, DOUT = 16'h0000;
    logic [15:0] rd4, rdo, rd2;
    logic        hit4, hito, hit2, tx4, txo, tx2;
    int          errs = 0, checks = 0;
    logic [7:0]  q4 [$];
    logic [7:0]  mb;

    always #5 Clock = ~Clock;

    mmio_uart_tx #(.CLKS_PER_BIT(4)) u4 (.Clock(Clock), .Reset(Reset), .ADDR(ADDR), .DOUT(DOUT), .W(W), .rdata(rd4), .hit(hit4), .tx(tx4));
    mmio_uart_tx #(.CLKS_PER_BIT(1000)) uo (.Clock(Clock), .Reset(Reset), .ADDR(ADDR), .DOUT(DOUT), .W(W), .rdata(rdo), .hit(hito), .tx(txo));
    mmio_uart_tx #(.CLKS_PER_BIT(2)) u2 (.Clock(Clock), .Reset(Reset), .ADDR(ADDR), .DOUT(DOUT), .W(W), .rdata(rd2), .hit(hit2), .tx(tx2));

    // frame bit j of byte b: start, 8 data bits LSB first, stop
    function automatic logic fbit(input logic [7:0] b, input int j);
        return j == 0 ? 1'b0 : j == 9 ? 1'b1 : b[j-1];
    endfunction

    // receiver on the 4-clock instance, sampling each bit mid-cell
    initial forever begin
        @(negedge Clock);
        if (!Reset && tx4 === 1'b0) begin
            repeat (6) @(negedge Clock);
            mb[0] = tx4;
            for (int k = 1; k < 8; k++) begin
                repeat (4) @(negedge Clock);
                mb[k] = tx4;
            end
            repeat (4) @(negedge Clock);
            q4.push_back(mb);
        end
    end

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        ADDR = a;
        DOUT = d;
        W = 1'b1;
        @(negedge Clock);
        W = 1'b0;
    endtask

    task automatic rst(input int n);
        Reset = 1'b1;
        repeat (n) @(negedge Clock);
        Reset = 1'b0;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge Clock);
        Reset = 1'b0;
        wr(16'h3000, 16'h0000);
        ADDR = 16'h3001;
        @(negedge Clock);
        checks++;
        if (tx4 !== 1'b0 || hit4 !== 1'b1) begin errs++; $display("FAIL pre_reset tx=%b hit=%b want tx=0 hit=1", tx4, hit4); end
        #2 Reset = 1'b1;
        #1;
        checks++;
        if ({tx4, hit4, rd4} !== {1'b1, 1'b0, 16'h0000}) begin errs++; $display("FAIL reset_u4 tx=%b hit=%b rdata=%h want 1 0 0000", tx4, hit4, rd4); end
        checks++;
        if ({txo, hito, rdo} !== {1'b1, 1'b0, 16'h0000}) begin errs++; $display("FAIL reset_uo tx=%b hit=%b rdata=%h want 1 0 0000", txo, hito, rdo); end
        checks++;
        if ({tx2, hit2, rd2} !== {1'b1, 1'b0, 16'h0000}) begin errs++; $display("FAIL reset_u2 tx=%b hit=%b rdata=%h want 1 0 0000", tx2, hit2, rd2); end
        @(negedge Clock);
        Reset = 1'b0;
        @(negedge Clock);
        checks++;
        if (rd4 !== 16'h0002 || rdo !== 16'h0002 || rd2 !== 16'h0002) begin errs++; $display("FAIL reset_status got %h %h %h want 0002", rd4, rdo, rd2); end
    endtask

    task automatic test_single;
        rst(2);
        wr(16'h3000, 16'hAB55);
        ADDR = 16'h3001;
        @(negedge Clock);
        for (int i = 0; i < 40; i++) begin
            checks++;
            if (tx4 !== fbit(8'h55, i / 4)) begin errs++; $display("FAIL single_tx cycle %0d got %b want %b", i, tx4, fbit(8'h55, i / 4)); end
            if (i == 20) begin
                checks++;
                if (rd4 !== 16'h0006) begin errs++; $display("FAIL single_busy got %h want 0006", rd4); end
            end
            @(negedge Clock);
        end
        checks++;
        if (tx4 !== 1'b1) begin errs++; $display("FAIL single_idle tx=%b want 1", tx4); end
        @(negedge Clock);
        checks++;
        if (rd4 !== 16'h0002) begin errs++; $display("FAIL single_after got %h want 0002", rd4); end
    endtask

    task automatic test_back_to_back;
        logic e;
        rst(2);
        wr(16'h3000, 16'h0000);
        wr(16'h3000, 16'h00FF);
        for (int i = 0; i < 41; i++) begin
            e = i < 20 ? fbit(8'h00, i / 2) : i == 20 ? 1'b1 : fbit(8'hFF, (i - 21) / 2);
            checks++;
            if (tx2 !== e) begin errs++; $display("FAIL b2b_tx cycle %0d got %b want %b", i, tx2, e); end
            @(negedge Clock);
        end
    endtask

    task automatic test_overflow;
        rst(50);
        q4.delete();
        for (int v = 1; v <= 10; v++) wr(16'h3000, 16'(v));
        ADDR = 16'h3001;
        @(negedge Clock);
        checks++;
        if (rdo !== 16'h008D || rd4 !== 16'h008D) begin errs++; $display("FAIL ovf_status got %h %h want 008D", rdo, rd4); end
        wr(16'h3001, 16'h0008);
        @(negedge Clock);
        checks++;
        if (rdo !== 16'h0085 || rd4 !== 16'h0085) begin errs++; $display("FAIL ovf_clear got %h %h want 0085", rdo, rd4); end
        repeat (400) @(negedge Clock);
        checks++;
        if (q4.size() != 9) begin errs++; $display("FAIL ovf_count got %0d bytes want 9", q4.size()); end
        for (int i = 0; i < 9 && i < q4.size(); i++) begin
            checks++;
            if (q4[i] !== 8'(i + 1)) begin errs++; $display("FAIL ovf_byte %0d got %h want %h", i, q4[i], 8'(i + 1)); end
        end
    endtask

    task automatic test_decode;
        int bad;
        rst(2);
        wr(16'h3002, 16'h0011);
        checks++;
        if (hit4 !== 1'b0) begin errs++; $display("FAIL decode_3002 hit=%b want 0", hit4); end
        wr(16'h2000, 16'h0022);
        checks++;
        if (hit4 !== 1'b0) begin errs++; $display("FAIL decode_2000 hit=%b want 0", hit4); end
        ADDR = 16'h3001;
        @(negedge Clock);
        checks++;
        if (rd4 !== 16'h0002 || hit4 !== 1'b1) begin errs++; $display("FAIL decode_status rdata=%h hit=%b want 0002 1", rd4, hit4); end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (tx4 !== 1'b1) bad++;
            @(negedge Clock);
        end
        checks++;
        if (bad != 0) begin errs++; $display("FAIL decode_tx low cycles=%0d want 0", bad); end
        ADDR = 16'h3000;
        @(negedge Clock);
        checks++;
        if (hit4 !== 1'b1 || rd4 !== 16'h0000) begin errs++; $display("FAIL decode_data hit=%b rdata=%h want 1 0000", hit4, rd4); end
    endtask

    task automatic test_reset_mid;
        int bad;
        rst(2);
        wr(16'h3000, 16'h0000);
        @(negedge Clock);
        repeat (17) @(negedge Clock);
        checks++;
        if (tx4 !== 1'b0) begin errs++; $display("FAIL mid_bit3 tx=%b want 0", tx4); end
        #2 Reset = 1'b1;
        #1;
        checks++;
        if (tx4 !== 1'b1 || rd4 !== 16'h0000) begin errs++; $display("FAIL mid_reset tx=%b rdata=%h want 1 0000", tx4, rd4); end
        @(negedge Clock);
        Reset = 1'b0;
        ADDR = 16'h3001;
        @(negedge Clock);
        checks++;
        if (rd4 !== 16'h0002) begin errs++; $display("FAIL mid_status got %h want 0002", rd4); end
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            if (tx4 !== 1'b1) bad++;
            @(negedge Clock);
        end
        checks++;
        if (bad != 0) begin errs++; $display("FAIL mid_quiet low cycles=%0d want 0", bad); end
    endtask

    initial begin
        test_reset;
        test_single;
        test_back_to_back;
        test_overflow;
        test_decode;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
